// File: rtl/keycode_evt_pkg.sv
// Shared types and constants for the keycode event queue: FSM states,
// reserved HID keycodes and the event record carried by the FIFO.
package keycode_evt_pkg;

    parameter int EVT_CODE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REL    = 2'd1,
        PRS    = 2'd2,
        COMMIT = 2'd3
    } kc_state_t;

    localparam logic [EVT_CODE_W-1:0] KC_EMPTY    = '0;
    localparam logic [EVT_CODE_W-1:0] KC_ROLLOVER = 8'h01;

    typedef struct packed {
        logic                  press;
        logic [EVT_CODE_W-1:0] code;
    } evt_t;

endpackage

// File: rtl/evt_fifo.sv
// Show-ahead event FIFO with registered head, level count and drop flag.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module evt_fifo
    import keycode_evt_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  evt_t                       din,
    input  logic                       ready,
    output logic                       valid,
    output evt_t                       head,
    output logic                       full,
    output logic                       drop,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    evt_t             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop;
    logic             wr;

    assign valid = (level != '0);
    assign full  = (level == LVL_W'(DEPTH));
    assign pop   = valid && ready;
    assign wr    = push && (!full || pop);
    assign drop  = push && !wr;
    assign head  = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once level covers them.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/keycode_event_queue.sv
// Turns HID keycode snapshots into ordered release/press events: releases of
// codes gone from the new snapshot first, then presses of new codes.
module keycode_event_queue
    import keycode_evt_pkg::*;
#(
    parameter int SLOTS  = 4,
    parameter int CODE_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic [SLOTS*CODE_W-1:0]    keycode_i,
    input  logic                       keycode_valid_i,
    output logic                       evt_valid_o,
    output logic [CODE_W-1:0]          evt_code_o,
    output logic                       evt_press_o,
    input  logic                       evt_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level_o,
    output logic [$clog2(SLOTS+1)-1:0] held_count_o,
    output logic                       busy_o,
    output logic                       overflow_o,
    input  logic                       clear_overflow_i
);

    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int HC_W  = $clog2(SLOTS+1);

    kc_state_t               state;
    logic [IDX_W-1:0]        idx;
    logic [SLOTS*CODE_W-1:0] prev, cur, pend;
    logic                    pend_v;
    logic                    strobe_ok, last_slot;
    logic [CODE_W-1:0]       prev_k, cur_k;
    logic                    rel_hit, prs_hit, push, drop;
    logic [HC_W-1:0]         cur_count;
    evt_t                    push_evt, head;

    // True when code appears in one of the first 'limit' slots of vec.
    function automatic logic in_slots(input logic [CODE_W-1:0] code,
                                      input logic [SLOTS*CODE_W-1:0] vec,
                                      input int limit);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < SLOTS; j++)
            if (j < limit && vec[j*CODE_W +: CODE_W] == code) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic is_phantom(input logic [SLOTS*CODE_W-1:0] vec);
        logic all_ro;
        all_ro = 1'b1;
        for (int j = 0; j < SLOTS; j++)
            if (vec[j*CODE_W +: CODE_W] != KC_ROLLOVER) all_ro = 1'b0;
        return all_ro;
    endfunction

    always_comb begin
        strobe_ok = keycode_valid_i && !is_phantom(keycode_i);
        last_slot = (idx == IDX_W'(SLOTS-1));
        prev_k    = prev[int'(idx)*CODE_W +: CODE_W];
        cur_k     = cur[int'(idx)*CODE_W +: CODE_W];
        rel_hit   = (prev_k != KC_EMPTY) && !in_slots(prev_k, cur, SLOTS)
                    && !in_slots(prev_k, prev, int'(idx));
        prs_hit   = (cur_k != KC_EMPTY) && !in_slots(cur_k, prev, SLOTS)
                    && !in_slots(cur_k, cur, int'(idx));
        push      = ((state == REL) && rel_hit) || ((state == PRS) && prs_hit);
        push_evt.press = (state == PRS);
        push_evt.code  = (state == PRS) ? cur_k : prev_k;
        cur_count = '0;
        for (int k = 0; k < SLOTS; k++)
            if (cur[k*CODE_W +: CODE_W] != KC_EMPTY
                && !in_slots(cur[k*CODE_W +: CODE_W], cur, k))
                cur_count = cur_count + HC_W'(1);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state        <= IDLE;
            idx          <= '0;
            prev         <= '0;
            cur          <= '0;
            pend         <= '0;
            pend_v       <= 1'b0;
            held_count_o <= '0;
        end else begin
            case (state)
                REL, PRS: begin
                    if (strobe_ok) begin
                        pend   <= keycode_i;
                        pend_v <= 1'b1;
                    end
                    idx <= last_slot ? '0 : idx + IDX_W'(1);
                    if (last_slot) state <= (state == REL) ? PRS : COMMIT;
                end
                default: begin
                    // IDLE and COMMIT share the load path so a pending snapshot
                    // starts its release walk with no idle cycle in between.
                    if (state == COMMIT) begin
                        prev         <= cur;
                        held_count_o <= cur_count;
                    end
                    idx <= '0;
                    if (pend_v) begin
                        cur    <= pend;
                        pend_v <= strobe_ok;
                        if (strobe_ok) pend <= keycode_i;
                        state  <= REL;
                    end else if (strobe_ok) begin
                        cur   <= keycode_i;
                        state <= REL;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)        overflow_o <= 1'b0;
        else if (drop)             overflow_o <= 1'b1;
        else if (clear_overflow_i) overflow_o <= 1'b0;
    end

    assign busy_o      = (state != IDLE);
    assign evt_code_o  = head.code;
    assign evt_press_o = head.press;

    evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .push  (push),
        .din   (push_evt),
        .ready (evt_ready_i),
        .valid (evt_valid_o),
        .head  (head),
        .full  (),
        .drop  (drop),
        .level (fifo_level_o)
    );

endmodule
